ycbcr_block_buffer: RTL and testbench

- Sits directly downstream of the RGB-to-YCbCr converter and upstream of the per-component DCT stages.
- Collects 24-bit YCbCr pixels, arriving in raster order on the converter's enable strobe, into 8x8 blocks in a ping-pong buffer.
- Level-shifts each component by -128 into signed 8-bit and streams each completed block as 64 consecutive samples, optionally transposed, under a downstream advance signal.
- Writing one bank while reading the other absorbs converter bursts and DCT stalls.

---
 rtl/ycbcr_block_buffer.sv | 179 +++++++++++++++++
 tb/tb_ycbcr_block_buffer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ycbcr_block_buffer.sv
// ycbcr_block_buffer: collects raster-order YCbCr pixels into 8x8 blocks in a
// ping-pong buffer and streams each finished block as 64 level-shifted signed
// samples, optionally transposed, under downstream out_ready flow control.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for full[rd_bank]; nothing is issued
// STREAM | issuing one sample per out_ready cycle from rd_bank, 0..63
module ycbcr_block_buffer #(
    parameter bit TRANSPOSE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [23:0]       data_in,
    input  logic              out_ready,
    output logic signed [7:0] y_out,
    output logic signed [7:0] cb_out,
    output logic signed [7:0] cr_out,
    output logic              enable_out,
    output logic              block_start,
    output logic              block_end,
    output logic              overflow
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  full_q, full_d;
    logic        wr_bank_q, wr_bank_d;
    logic [5:0]  wr_cnt_q, wr_cnt_d;
    logic        rd_bank_q, rd_bank_d;
    logic [5:0]  rd_cnt_q, rd_cnt_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  y_q, y_d;
    logic [7:0]  cb_q, cb_d;
    logic [7:0]  cr_q, cr_d;
    logic        enable_out_q, enable_out_d;
    logic        block_start_q, block_start_d;
    logic        block_end_q, block_end_d;

    // Bank select is the MSB of the storage index; entries are not reset,
    // since the full flags alone decide what is valid.
    logic [23:0] mem [0:127];

    logic        wr_en;
    logic        wr_last;
    logic        issue;
    logic        rd_last;
    logic [5:0]  rd_addr;
    logic [23:0] rd_word;

    // Write side: accept into the current bank unless its registered full flag is set
    always_comb begin
        wr_en      = enable && !full_q[wr_bank_q];
        wr_last    = wr_en && (wr_cnt_q == 6'd63);
        wr_cnt_d   = wr_cnt_q;
        wr_bank_d  = wr_bank_q;
        overflow_d = overflow_q;
        if (wr_en) begin
            wr_cnt_d = wr_cnt_q + 6'd1;
        end
        if (wr_last) begin
            wr_bank_d = ~wr_bank_q;
        end
        if (enable && full_q[wr_bank_q]) begin
            overflow_d = 1'b1;
        end
    end

    // Read FSM: next state, read counter and bank, issue strobe
    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        issue     = 1'b0;
        rd_last   = 1'b0;
        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d  = STREAM;
                    rd_cnt_d = 6'd0;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    issue    = 1'b1;
                    rd_cnt_d = rd_cnt_q + 6'd1;
                    if (rd_cnt_q == 6'd63) begin
                        rd_last   = 1'b1;
                        rd_bank_d = ~rd_bank_q;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Full flags: set by the write side and cleared by the read side, always on opposite banks
    always_comb begin
        full_d = full_q;
        if (wr_last) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (rd_last) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    // Output stage: fetch the addressed entry and level-shift by flipping each MSB
    always_comb begin
        rd_addr       = TRANSPOSE ? {rd_cnt_q[2:0], rd_cnt_q[5:3]} : rd_cnt_q;
        rd_word       = mem[{rd_bank_q, rd_addr}];
        enable_out_d  = issue;
        block_start_d = issue && (rd_cnt_q == 6'd0);
        block_end_d   = rd_last;
        y_d           = y_q;
        cb_d          = cb_q;
        cr_d          = cr_q;
        if (issue) begin
            y_d  = {~rd_word[7],  rd_word[6:0]};
            cb_d = {~rd_word[15], rd_word[14:8]};
            cr_d = {~rd_word[23], rd_word[22:16]};
        end
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            full_q        <= 2'b00;
            wr_bank_q     <= 1'b0;
            wr_cnt_q      <= 6'd0;
            rd_bank_q     <= 1'b0;
            rd_cnt_q      <= 6'd0;
            overflow_q    <= 1'b0;
            y_q           <= 8'd0;
            cb_q          <= 8'd0;
            cr_q          <= 8'd0;
            enable_out_q  <= 1'b0;
            block_start_q <= 1'b0;
            block_end_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            full_q        <= full_d;
            wr_bank_q     <= wr_bank_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_bank_q     <= rd_bank_d;
            rd_cnt_q      <= rd_cnt_d;
            overflow_q    <= overflow_d;
            y_q           <= y_d;
            cb_q          <= cb_d;
            cr_q          <= cr_d;
            enable_out_q  <= enable_out_d;
            block_start_q <= block_start_d;
            block_end_q   <= block_end_d;
        end
    end

    // Pixel storage write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank_q, wr_cnt_q}] <= data_in;
        end
    end

    assign y_out       = y_q;
    assign cb_out      = cb_q;
    assign cr_out      = cr_q;
    assign enable_out  = enable_out_q;
    assign block_start = block_start_q;
    assign block_end   = block_end_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ycbcr_block_buffer.sv
// Directed bench for ycbcr_block_buffer: a raster-order instance and a
// transposed instance share the same stimulus; outputs are captured on the
// falling edge and compared against hand-computed expectations.
module tb_ycbcr_block_buffer;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic [23:0]       data_in = 24'd0;
    logic              out_ready = 1'b1;
    logic signed [7:0] y0, cb0, cr0, y1, cb1, cr1;
    logic              en0, bs0, be0, ov0, en1, bs1, be1, ov1;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int gate_err = 0;
    int last_push_cyc = 0;
    int q_y[$], q_cb[$], q_cr[$], q_bs[$], q_be[$], q_cyc[$], q1_y[$];

    typedef struct {
        logic [7:0] in;
        int         exp;
    } vec_t;
    vec_t vecs[8];

    ycbcr_block_buffer #(.TRANSPOSE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .data_in(data_in), .out_ready(out_ready),
        .y_out(y0), .cb_out(cb0), .cr_out(cr0), .enable_out(en0),
        .block_start(bs0), .block_end(be0), .overflow(ov0)
    );

    ycbcr_block_buffer #(.TRANSPOSE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .data_in(data_in), .out_ready(out_ready),
        .y_out(y1), .cb_out(cb1), .cr_out(cr1), .enable_out(en1),
        .block_start(bs1), .block_end(be1), .overflow(ov1)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!en0 && (bs0 || be0)) gate_err++;
        if (!en1 && (bs1 || be1)) gate_err++;
        if (en0) begin
            q_y.push_back(int'(y0));
            q_cb.push_back(int'(cb0));
            q_cr.push_back(int'(cr0));
            q_bs.push_back(int'(bs0));
            q_be.push_back(int'(be0));
            q_cyc.push_back(cyc);
        end
        if (en1) q1_y.push_back(int'(y1));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic clear_q();
        q_y.delete(); q_cb.delete(); q_cr.delete();
        q_bs.delete(); q_be.delete(); q_cyc.delete(); q1_y.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_q();
    endtask

    task automatic push(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        @(posedge clk); #1;
        enable = 1'b1;
        data_in = {cr, cb, y};
        last_push_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            enable = 1'b0;
        end
    endtask

    task automatic wait_out(input int n, input int budget, input string name);
        int b;
        b = budget;
        while (q_y.size() < n && b > 0) begin
            @(posedge clk);
            b--;
        end
        if (q_y.size() < n) check(name, q_y.size(), n);
    endtask

    initial begin
        int c_last;
        int idx;

        vecs[0] = '{8'd0,   -128};
        vecs[1] = '{8'd128,    0};
        vecs[2] = '{8'd255,  127};
        vecs[3] = '{8'd1,   -127};
        vecs[4] = '{8'd127,   -1};
        vecs[5] = '{8'd129,    1};
        vecs[6] = '{8'd64,   -64};
        vecs[7] = '{8'd200,   72};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_y", int'(y0), 0);
        check("rst_cb", int'(cb0), 0);
        check("rst_cr", int'(cr0), 0);
        check("rst_en", int'(en0), 0);
        check("rst_bs", int'(bs0), 0);
        check("rst_be", int'(be0), 0);
        check("rst_ov", int'(ov0), 0);
        @(posedge clk); #1 rst = 1'b0;
        clear_q();

        // Single block, raster and transposed readout, latency
        for (int k = 0; k < 64; k++) push(8'(k), 8'(255 - k), 8'd128);
        c_last = last_push_cyc;
        idle(1);
        wait_out(64, 200, "t1_timeout");
        for (int k = 0; k < 64; k++) begin
            check($sformatf("t1_y[%0d]", k), q_y[k], k - 128);
            check($sformatf("t1_cb[%0d]", k), q_cb[k], 127 - k);
            check($sformatf("t1_cr[%0d]", k), q_cr[k], 0);
            check($sformatf("t1_bs[%0d]", k), q_bs[k], (k == 0) ? 1 : 0);
            check($sformatf("t1_be[%0d]", k), q_be[k], (k == 63) ? 1 : 0);
            check($sformatf("t2_y[%0d]", k), q1_y[k], ((k % 8) * 8 + k / 8) - 128);
        end
        check("t1_first_cycle", q_cyc[0], c_last + 3);
        check("t1_last_cycle", q_cyc[63], c_last + 66);
        check("t1_ov", int'(ov0), 0);

        // Level-shift table across all three components
        do_reset();
        for (int k = 0; k < 64; k++)
            push(vecs[k % 8].in, vecs[(k + 3) % 8].in, vecs[(k + 5) % 8].in);
        idle(1);
        wait_out(64, 200, "tv_timeout");
        for (int k = 0; k < 64; k++) begin
            check($sformatf("tv_y[%0d]", k), q_y[k], vecs[k % 8].exp);
            check($sformatf("tv_cb[%0d]", k), q_cb[k], vecs[(k + 3) % 8].exp);
            check($sformatf("tv_cr[%0d]", k), q_cr[k], vecs[(k + 5) % 8].exp);
        end

        // Three blocks; one idle cycle before the third, since the first write
        // of block 3 would otherwise land in the cycle bank 0 is being freed
        do_reset();
        for (int n = 0; n < 128; n++) push(8'(n), 8'(n / 64), 8'(255 - n));
        idle(1);
        for (int n = 128; n < 192; n++) push(8'(n), 8'(n / 64), 8'(255 - n));
        idle(1);
        wait_out(192, 500, "t3_timeout");
        for (int n = 0; n < 192; n++) begin
            check($sformatf("t3_y[%0d]", n), q_y[n], n - 128);
            check($sformatf("t3_cb[%0d]", n), q_cb[n], n / 64 - 128);
            check($sformatf("t3_cr[%0d]", n), q_cr[n], 127 - n);
            check($sformatf("t3_bs[%0d]", n), q_bs[n], (n % 64 == 0) ? 1 : 0);
            check($sformatf("t3_be[%0d]", n), q_be[n], (n % 64 == 63) ? 1 : 0);
            if (n % 64 != 63)
                check($sformatf("t3_gap[%0d]", n), q_cyc[n + 1] - q_cyc[n], 1);
        end
        check("t3_ov", int'(ov0), 0);

        // Strictly back-to-back 129th input hits bank 0 the cycle it is freed
        do_reset();
        for (int n = 0; n < 129; n++) push(8'(n), 8'd0, 8'd0);
        idle(1);
        @(negedge clk);
        check("t3b_ov", int'(ov0), 1);
        wait_out(128, 400, "t3b_timeout");
        idle(10);
        check("t3b_count", q_y.size(), 128);
        check("t3b_y64", q_y[64], 64 - 128);
        check("t3b_y127", q_y[127], -1);

        // Both banks full under backpressure, extra input dropped
        do_reset();
        out_ready = 1'b0;
        for (int n = 0; n < 128; n++) push(8'(n), 8'd5, 8'd6);
        push(8'd200, 8'd200, 8'd200);
        idle(10);
        check("t4_ov", int'(ov0), 1);
        check("t4_held", q_y.size(), 0);
        out_ready = 1'b1;
        wait_out(128, 400, "t4_timeout");
        idle(10);
        check("t4_count", q_y.size(), 128);
        for (int n = 0; n < 128; n++)
            check($sformatf("t4_y[%0d]", n), q_y[n], n - 128);
        check("t4_ov_sticky", int'(ov0), 1);

        // out_ready toggling every cycle during streaming
        do_reset();
        for (int k = 0; k < 64; k++) push(8'(k), 8'd0, 8'd0);
        idle(1);
        wait_out(1, 50, "t5_start_timeout");
        for (int t = 0; t < 140; t++) begin
            #1 out_ready = t[0];
            @(posedge clk);
        end
        #1 out_ready = 1'b1;
        wait_out(64, 100, "t5_timeout");
        idle(5);
        check("t5_count", q_y.size(), 64);
        for (int k = 0; k < 64; k++)
            check($sformatf("t5_y[%0d]", k), q_y[k], k - 128);
        for (int k = 1; k < 63; k++)
            check($sformatf("t5_gap[%0d]", k), q_cyc[k + 1] - q_cyc[k], 2);

        // Reset in the middle of a streamed block
        do_reset();
        for (int k = 0; k < 64; k++) push(8'(k), 8'(k), 8'(k));
        idle(1);
        wait_out(21, 100, "t6_mid_timeout");
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_rst_y", int'(y0), 0);
        check("t6_rst_cb", int'(cb0), 0);
        check("t6_rst_cr", int'(cr0), 0);
        check("t6_rst_en", int'(en0), 0);
        check("t6_rst_bs", int'(bs0), 0);
        check("t6_rst_be", int'(be0), 0);
        check("t6_rst_ov", int'(ov0), 0);
        @(posedge clk); #1 rst = 1'b0;
        clear_q();
        for (int k = 0; k < 64; k++) push(8'(k + 64), 8'(k), 8'(255 - k));
        idle(1);
        wait_out(64, 200, "t6_timeout");
        idle(10);
        check("t6_count", q_y.size(), 64);
        for (int k = 0; k < 64; k++) begin
            idx = k + 64;
            check($sformatf("t6_y[%0d]", k), q_y[k], idx - 128);
            check($sformatf("t6_cr[%0d]", k), q_cr[k], 127 - k);
            check($sformatf("t6_bs[%0d]", k), q_bs[k], (k == 0) ? 1 : 0);
        end
        check("t6_ov", int'(ov0), 0);

        check("gate_start_end", gate_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
